demux3bit122_stream: RTL and testbench
======================================

DEMUX3BIT122_STREAM -- requirements
Module: demux3bit122_stream

Interface
REQ-001 Parameter: DEPTH, default 2, per-port queue depth in entries; SHALL be a power of two, >= 2.
REQ-002 Parameter: CNT_W, default 8, width of per-port transfer counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_data  input  3  payload to route.
REQ-006 in_sel  input  1  destination: 0 = port A, 1 = port B.
REQ-007 in_valid  input  1  source offers in_data/in_sel this cycle.
REQ-008 in_ready  output  1  block accepts the offered beat this cycle.
REQ-009 a_data / b_data  output  3 each  head-of-queue payload, port A / B.
REQ-010 a_valid / b_valid  output  1 each  port queue non-empty.
REQ-011 a_ready / b_ready  input  1 each  sink consumes head this cycle.
REQ-012 a_cnt / b_cnt  output  CNT_W each  beats delivered to sink, per port.
REQ-013 a_full / b_full  output  1 each  port queue holds DEPTH entries.

Function
REQ-014 Input handshake: beat accepted when in_valid && in_ready on a rising edge; in_ready SHALL be combinational = NOT full of the queue addressed by in_sel.
REQ-015 Accepted beat SHALL be written to the tail of the queue selected by in_sel; the other queue SHALL be unchanged by it.
REQ-016 Output handshake per port: beat consumed when x_valid && x_ready; head pointer advances, occupancy decrements.
REQ-017 Each queue SHALL be FIFO-ordered: beats leave a port in the order accepted for that port.
REQ-018 Latency: beat accepted in cycle N SHALL be visible on x_data with x_valid=1 in cycle N+1 if queue was empty; no combinational path from in_data to x_data.
REQ-019 x_data SHALL be stable while x_valid=1 and x_ready=0.
REQ-020 Each port SHALL keep a 3-state occupancy FSM: EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions follow count after each edge.
REQ-021 Simultaneous write and read on same port in one cycle: count unchanged; allowed in PARTIAL; in FULL write is blocked (in_ready=0) even if x_ready=1 that cycle; in EMPTY only the write occurs.
REQ-022 Write to one port concurrent with read from the other: both SHALL complete in the same cycle.
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 x_cnt SHALL increment by 1 per consumed beat on that port and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-025 in_valid=0: no queue state change regardless of in_sel/in_data; in_ready still reflects selected queue.
REQ-026 Full queue on one port SHALL NOT block beats addressed to the other port.

Reset
REQ-027 While rst_n=0 at a rising edge: both queues EMPTY, pointers 0, a_cnt=b_cnt=0, a_valid=b_valid=0, a_full=b_full=0; a_data/b_data SHALL read 3'b000.
REQ-028 Reset mid-operation SHALL discard all queued beats; no beat accepted or consumed on a reset edge; in_ready during reset SHALL be 1 per REQ-014 applied to empty queues.
REQ-029 First accept possible on the first rising edge with rst_n=1.

Verification
REQ-030 Reset, then in_valid=1, in_sel=0, in_data=3'b101 one cycle, a_ready=0 -> next cycle a_valid=1, a_data=101, b_valid=0, a_cnt=0.
REQ-031 DEPTH=2, a_ready=0, push 3'b001, 3'b010 to A -> a_full=1; third beat with in_sel=0 sees in_ready=0; same cycle in_sel=1, 3'b111 accepted, b_data=111 next cycle.
REQ-032 Port A full, a_ready=1 and in_valid=1 in_sel=0 same cycle -> write rejected, one beat consumed, a_cnt +1; next cycle in_ready=1.
REQ-033 Interleaved stream A:1,B:2,A:3,B:4 with both ready=1 -> A delivers 1 then 3, B delivers 2 then 4, a_cnt=b_cnt=2.
REQ-034 CNT_W=8, deliver 256 beats on B -> b_cnt returns to 0; pointer wrap causes no data loss or reorder.
REQ-035 Fill both queues, assert rst_n=0 one cycle -> all valids 0, counters 0, a_data=b_data=000, in_ready=1 after reset.

Source files
------------

// File: rtl/demux3bit122_stream.sv
// demux3bit122_stream
//   Routes a 3-bit input stream to one of two buffered output ports.
//   Each port has a DEPTH-entry FIFO, an EMPTY/PARTIAL/FULL occupancy FSM
//   and a wrapping count of delivered beats.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_data/in_sel        payload and destination (0 = A, 1 = B)
//   in_valid/in_ready     input handshake; in_ready = !full(selected port)
//   a_/b_data, _valid     head of queue (data reads 0 while empty)
//   a_/b_ready            sink consumes head
//   a_/b_cnt              beats delivered per port (wraps silently)
//   a_/b_full             queue holds DEPTH entries

module demux3bit122_stream_port #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_data,
  input  logic             rd_ready,
  output logic [2:0]       data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_e;

  occ_e                  state, state_nxt;
  logic [OW-1:0]         occ, occ_nxt;
  logic [AW-1:0]         wptr, rptr;
  logic [DEPTH-1:0][2:0] mem;
  logic                  wr, rd;

  assign valid = (state != ST_EMPTY);
  assign full  = (state == ST_FULL);
  // A full queue never takes a write, even when its head leaves this cycle.
  assign wr    = wr_en & ~full;
  assign rd    = valid & rd_ready;
  // Storage is not cleared on reset, so mask the head while empty.
  assign data  = valid ? mem[rptr] : 3'b000;

  always_comb begin
    occ_nxt   = occ;
    state_nxt = state;
    case ({wr, rd})
      2'b10:   occ_nxt = occ + OW'(1);
      2'b01:   occ_nxt = occ - OW'(1);
      default: occ_nxt = occ;
    endcase
    if (occ_nxt == '0)             state_nxt = ST_EMPTY;
    else if (occ_nxt == OW'(DEPTH)) state_nxt = ST_FULL;
    else                            state_nxt = ST_PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      occ   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      if (wr) wptr <= wptr + AW'(1);
      if (rd) begin
        rptr <= rptr + AW'(1);
        cnt  <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr) mem[wptr] <= wr_data;
  end
endmodule

module demux3bit122_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic             a_full,
  output logic [2:0]       b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] b_cnt,
  output logic             b_full
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            sel_oh, pwr, prdy, pvld, pfull;
  logic [NUM_PORTS-1:0][2:0]       pdata;
  logic [NUM_PORTS-1:0][CNT_W-1:0] pcnt;

  assign sel_oh   = {in_sel, ~in_sel};
  assign in_ready = ~pfull[in_sel];
  assign pwr      = sel_oh & {NUM_PORTS{in_valid & in_ready}};
  assign prdy     = {b_ready, a_ready};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    demux3bit122_stream_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (pwr[g]),
      .wr_data  (in_data),
      .rd_ready (prdy[g]),
      .data     (pdata[g]),
      .valid    (pvld[g]),
      .full     (pfull[g]),
      .cnt      (pcnt[g])
    );
  end

  assign a_data  = pdata[0];
  assign a_valid = pvld[0];
  assign a_full  = pfull[0];
  assign a_cnt   = pcnt[0];
  assign b_data  = pdata[1];
  assign b_valid = pvld[1];
  assign b_full  = pfull[1];
  assign b_cnt   = pcnt[1];
endmodule

// File: tb/tb_demux3bit122_stream.sv
module tb_demux3bit122_stream;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       in_data;
  logic             in_sel, in_valid, in_ready;
  logic [2:0]       a_data, b_data;
  logic             a_valid, b_valid, a_ready, b_ready, a_full, b_full;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] qa[$];
  logic [2:0] qb[$];
  int acnt_m = 0;
  int bcnt_m = 0;

  always #5 clk = ~clk;

  demux3bit122_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready), .a_cnt(a_cnt), .a_full(a_full),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .b_cnt(b_cnt), .b_full(b_full)
  );

  // One clock cycle with the scoreboard: heads are compared and popped on
  // consume, accepted beats are pushed, ready/full/count checked against
  // the bench's own occupancy model.
  task automatic tick();
    logic exp_rdy, rst_seen, exp_afull, exp_bfull;
    @(negedge clk);
    rst_seen = !rst_n;
    if (!rst_seen) begin
      exp_rdy   = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
      exp_afull = (qa.size() == DEPTH);
      exp_bfull = (qb.size() == DEPTH);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL sb_in_ready got %0b want %0b", in_ready, exp_rdy);
      end
      n_cmp++;
      if (a_full !== exp_afull || b_full !== exp_bfull) begin
        n_err++; $display("FAIL sb_full got a=%0b b=%0b want a=%0b b=%0b", a_full, b_full, exp_afull, exp_bfull);
      end
      n_cmp++;
      if (a_cnt !== 8'(acnt_m) || b_cnt !== 8'(bcnt_m)) begin
        n_err++; $display("FAIL sb_cnt got a=%0d b=%0d want a=%0d b=%0d", a_cnt, b_cnt, 8'(acnt_m), 8'(bcnt_m));
      end
      n_cmp++;
      if (qa.size() > 0) begin
        if (a_valid !== 1'b1 || a_data !== qa[0]) begin
          n_err++; $display("FAIL sb_a_head got v=%0b d=%0d want v=1 d=%0d", a_valid, a_data, qa[0]);
        end
        if (a_ready) begin void'(qa.pop_front()); acnt_m++; end
      end else if (a_valid !== 1'b0 || a_data !== 3'd0) begin
        n_err++; $display("FAIL sb_a_empty got v=%0b d=%0d want v=0 d=0", a_valid, a_data);
      end
      n_cmp++;
      if (qb.size() > 0) begin
        if (b_valid !== 1'b1 || b_data !== qb[0]) begin
          n_err++; $display("FAIL sb_b_head got v=%0b d=%0d want v=1 d=%0d", b_valid, b_data, qb[0]);
        end
        if (b_ready) begin void'(qb.pop_front()); bcnt_m++; end
      end else if (b_valid !== 1'b0 || b_data !== 3'd0) begin
        n_err++; $display("FAIL sb_b_empty got v=%0b d=%0d want v=0 d=0", b_valid, b_data);
      end
      if (in_valid && exp_rdy) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
    @(posedge clk); #1;
    if (rst_seen) begin
      qa.delete(); qb.delete(); acnt_m = 0; bcnt_m = 0;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sel = 1'b0; in_data = 3'd0; a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if (a_valid !== 0 || b_valid !== 0 || a_full !== 0 || b_full !== 0) begin
      n_err++; $display("FAIL reset_flags got av=%0b bv=%0b af=%0b bf=%0b want 0", a_valid, b_valid, a_full, b_full);
    end
    n_cmp++;
    if (a_cnt !== 0 || b_cnt !== 0 || a_data !== 0 || b_data !== 0) begin
      n_err++; $display("FAIL reset_vals got ac=%0d bc=%0d ad=%0d bd=%0d want 0", a_cnt, b_cnt, a_data, b_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b101; a_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (a_valid !== 1'b1 || a_data !== 3'b101 || b_valid !== 1'b0 || a_cnt !== 0) begin
      n_err++; $display("FAIL single got av=%0b ad=%0d bv=%0b ac=%0d want 1 5 0 0", a_valid, a_data, b_valid, a_cnt);
    end
    // Idle in_valid with toggled select must not disturb either queue.
    in_sel = 1'b1; in_data = 3'b111;
    tick(); tick();
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
  endtask

  task automatic test_full_other();
    in_valid = 1'b1; in_sel = 1'b0;
    in_data = 3'b001; tick();
    in_data = 3'b010; tick();
    n_cmp++;
    if (a_full !== 1'b1) begin
      n_err++; $display("FAIL full_a got %0b want 1", a_full);
    end
    in_data = 3'b011; #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_block got %0b want 0", in_ready);
    end
    in_sel = 1'b1; in_data = 3'b111; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL other_ready got %0b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (b_valid !== 1'b1 || b_data !== 3'b111) begin
      n_err++; $display("FAIL other_data got v=%0b d=%0d want v=1 d=7", b_valid, b_data);
    end
  endtask

  task automatic test_full_rw();
    int a0;
    a0 = acnt_m;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b100; a_ready = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_rw_block got %0b want 0", in_ready);
    end
    tick();
    in_valid = 1'b0; a_ready = 1'b0; #1;
    n_cmp++;
    if (a_cnt !== 8'(a0 + 1) || a_full !== 1'b0) begin
      n_err++; $display("FAIL full_rw_cnt got c=%0d f=%0b want c=%0d f=0", a_cnt, a_full, 8'(a0 + 1));
    end
    n_cmp++;
    if (in_ready !== 1'b1 || a_data !== 3'b010) begin
      n_err++; $display("FAIL full_rw_after got r=%0b d=%0d want r=1 d=2", in_ready, a_data);
    end
    a_ready = 1'b1; b_ready = 1'b1;
    tick(); tick(); tick();
    a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_interleave();
    logic [3:0] seq_d;
    logic [3:0] seq_s;
    seq_d = 4'b0000;
    do_reset();
    a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq_s = 4'b1010;
      seq_d = 4'(i + 1);
      in_sel = seq_s[i]; in_data = seq_d[2:0];
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (a_cnt !== 8'd2 || b_cnt !== 8'd2) begin
      n_err++; $display("FAIL interleave_cnt got a=%0d b=%0d want 2 2", a_cnt, b_cnt);
    end
    a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int sent_b, cyc;
    logic acc;
    do_reset();
    sent_b = 0; cyc = 0;
    while (sent_b < 256 && cyc < 5000) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 2) != 0);
      in_data  = 3'($urandom_range(0, 7));
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 3) != 0);
      acc = in_valid && in_sel && (qb.size() < DEPTH);
      tick();
      if (acc) sent_b++;
      cyc++;
    end
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    while ((qa.size() > 0 || qb.size() > 0) && cyc < 5100) begin
      tick(); cyc++;
    end
    n_cmp++;
    if (sent_b != 256 || qb.size() != 0) begin
      n_err++; $display("FAIL wrap_timeout sent %0d pending %0d want 256 0", sent_b, qb.size());
    end
    n_cmp++;
    if (b_cnt !== 8'd0 || b_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_cnt got c=%0d v=%0b want c=0 v=0", b_cnt, b_valid);
    end
    a_ready = 1'b0; b_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_sel = 1'b0; in_data = 3'd1; tick(); in_data = 3'd2; tick();
    in_sel = 1'b1; in_data = 3'd3; tick(); in_data = 3'd4; tick();
    in_sel = 1'b0; in_data = 3'd5;
    n_cmp++;
    if (a_full !== 1'b1 || b_full !== 1'b1) begin
      n_err++; $display("FAIL mid_fill got af=%0b bf=%0b want 1 1", a_full, b_full);
    end
    a_ready = 1'b1;
    do_reset();
    in_valid = 1'b0; a_ready = 1'b0; #1;
    n_cmp++;
    if (a_valid !== 0 || b_valid !== 0 || a_cnt !== 0 || b_cnt !== 0 || a_data !== 0 || b_data !== 0) begin
      n_err++; $display("FAIL mid_reset got av=%0b bv=%0b ac=%0d bc=%0d ad=%0d bd=%0d want 0",
                        a_valid, b_valid, a_cnt, b_cnt, a_data, b_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || a_full !== 0 || b_full !== 0) begin
      n_err++; $display("FAIL mid_ready got r=%0b af=%0b bf=%0b want 1 0 0", in_ready, a_full, b_full);
    end
    tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_full_other();
    test_full_rw();
    test_interleave();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
